ospfb_axis_capture: RTL and testbench

Single-clock AXI-Stream sink that captures a fixed number of OSPFB output frames into on-chip RAM for bench readback and hardware snapshot. It sits directly downstream of the OSPFB FFT output and consumes its complex samples. It aligns to frame boundaries using `tlast`, optionally discards warm-up frames, then writes `FRAMES*FFT_LEN` words and raises `full`. After capture, a synchronous read port exposes the RAM.

---
 rtl/alpaca_ospfb_capture_pkg.sv | 20 ++
 rtl/ospfb_axis_capture_ram.sv | 38 +++
 rtl/ospfb_axis_capture.sv | 159 +++++++++++++++
 tb/tb_ospfb_axis_capture.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alpaca_ospfb_capture_pkg.sv
// Shared types and width helpers for the OSPFB AXI-Stream capture block.
package alpaca_ospfb_capture_pkg;

    // Capture FSM states. The encoding is visible on the top-level dbg_state port.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALIGN   = 3'd1,
        SKIP    = 3'd2,
        CAPTURE = 3'd3,
        FULL    = 3'd4
    } capture_state_t;

    localparam int STATE_W = 3;

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ospfb_axis_capture_ram.sv
// Simple dual-port capture RAM: one write port and one registered read port.
// The read is read-first: reading an address in the same cycle it is written
// returns the previous contents.
import alpaca_ospfb_capture_pkg::*;

module capture_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 2048,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared by reset so readback starts from a known value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ospfb_axis_capture.sv
// AXI-Stream sink that aligns to OSPFB frame boundaries, discards SKIP_FRAMES
// warm-up frames, then stores FRAMES*FFT_LEN samples and raises full.
// The sink never backpressures: tready is 1 from the first edge after reset.
// Optional build macro OSPFB_CAPTURE_TLAST_CHECK_EN enables a sticky tlast_err
// flag that marks captured beats whose tlast disagrees with the frame position.
//
// Handshake: a beat moves when s_axis_tvalid & s_axis_tready are both high on
// a rising clk edge; beats outside CAPTURE are accepted and discarded.
import alpaca_ospfb_capture_pkg::*;

module ospfb_axis_capture #(
    parameter int WIDTH       = 16,
    parameter int FFT_LEN     = 64,
    parameter int FRAMES      = 32,
    parameter int SKIP_FRAMES = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 arm,
    input  logic [2*WIDTH-1:0]                   s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    output logic                                 full,
    output logic                                 busy,
    output logic [$clog2(FRAMES+1)-1:0]          frame_cnt,
    output logic                                 tlast_err,
    input  logic [$clog2(FRAMES*FFT_LEN)-1:0]    rd_addr,
    output logic [2*WIDTH-1:0]                   rd_data,
    output logic [STATE_W-1:0]                   dbg_state
);

    localparam int SAMP = FRAMES * FFT_LEN;
    localparam int AW   = $clog2(SAMP);
    localparam int FW   = $clog2(FRAMES + 1);
    localparam int PW   = cnt_w(FFT_LEN);
    localparam int SW   = cnt_w(SKIP_FRAMES + 1);

    // wr_ptr carries one extra bit so it can sit at SAMP without wrapping.
    localparam logic [AW:0]   LAST_PTR  = (AW+1)'(SAMP - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(FFT_LEN - 1);
    localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    capture_state_t state, next_state;

    logic          beat;
    logic          wr_en;
    logic          pos_last;
    logic          clear_cnt;
    logic [AW:0]   wr_ptr;
    logic [PW-1:0] pos;
    logic [SW-1:0] skip_cnt;

    assign beat      = s_axis_tvalid & s_axis_tready;
    assign wr_en     = beat & (state == CAPTURE);
    assign pos_last  = (pos == POS_LAST);
    assign clear_cnt = arm & ((state == IDLE) | (state == FULL));
    assign dbg_state = state;

    // Next-state logic; arm is only honoured in IDLE and FULL.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (arm) next_state = ALIGN;
            end
            ALIGN: begin
                if (beat && s_axis_tlast) begin
                    if (SKIP_FRAMES == 0) next_state = CAPTURE;
                    else                  next_state = SKIP;
                end
            end
            SKIP: begin
                if (beat && s_axis_tlast && (skip_cnt == SKIP_LAST)) next_state = CAPTURE;
            end
            CAPTURE: begin
                if (wr_en && (wr_ptr == LAST_PTR)) next_state = FULL;
            end
            FULL: begin
                if (arm) next_state = ALIGN;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register plus registered busy/full decodes and the ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            full          <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= next_state;
            busy          <= (next_state == ALIGN) || (next_state == SKIP) ||
                             (next_state == CAPTURE);
            full          <= (next_state == FULL);
            s_axis_tready <= 1'b1;
        end
    end

    // Write pointer, in-frame position, frame and skip counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            pos       <= '0;
            frame_cnt <= '0;
            skip_cnt  <= '0;
        end else if (clear_cnt) begin
            wr_ptr    <= '0;
            pos       <= '0;
            frame_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            if (state == ALIGN) begin
                skip_cnt <= '0;
            end else if ((state == SKIP) && beat && s_axis_tlast) begin
                skip_cnt <= skip_cnt + SW'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
                pos    <= pos_last ? '0 : pos + PW'(1);
                if (pos_last) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

`ifdef OSPFB_CAPTURE_TLAST_CHECK_EN
    // Sticky framing error: captured beat whose tlast disagrees with its position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlast_err <= 1'b0;
        end else if (clear_cnt) begin
            tlast_err <= 1'b0;
        end else if (wr_en && (s_axis_tlast != pos_last)) begin
            tlast_err <= 1'b1;
        end
    end
`else
    assign tlast_err = 1'b0;
`endif

    capture_ram #(
        .DW    (2*WIDTH),
        .DEPTH (SAMP),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ospfb_axis_capture.sv
// Bench for ospfb_axis_capture with FFT_LEN=8, FRAMES=2, SKIP_FRAMES=1.
// Every accepted beat since the last arm is logged; expected capture contents,
// counters and flags are derived from that log by list arithmetic.
module tb_ospfb_axis_capture;
    import alpaca_ospfb_capture_pkg::*;

    localparam int W    = 16;
    localparam int FL   = 8;
    localparam int FR   = 2;
    localparam int SK   = 1;
    localparam int SAMP = FL * FR;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        full;
    logic        busy;
    logic [1:0]  frame_cnt;
    logic        tlast_err;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  dbg_state;

    ospfb_axis_capture #(
        .WIDTH(W), .FFT_LEN(FL), .FRAMES(FR), .SKIP_FRAMES(SK)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .full(full), .busy(busy), .frame_cnt(frame_cnt), .tlast_err(tlast_err),
        .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cnt      = 0;
    bit          armed    = 1'b0;
    bit          inj_en   = 1'b0;
    logic [31:0] acc_data[$];
    bit          acc_last[$];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Index of the first beat stored in RAM, or -1 if capture has not started.
    function automatic int cap_start();
        int lasts = 0;
        if (!armed) return -1;
        foreach (acc_last[i]) begin
            if (lasts == SK + 1) return i;
            if (acc_last[i]) lasts++;
        end
        return -1;
    endfunction

    function automatic int captured_n();
        int s = cap_start();
        int n;
        if (s < 0) return 0;
        n = acc_last.size() - s;
        return (n > SAMP) ? SAMP : n;
    endfunction

    function automatic bit exp_err();
`ifdef OSPFB_CAPTURE_TLAST_CHECK_EN
        int s = cap_start();
        int n = captured_n();
        for (int k = 0; k < n; k++) begin
            if (acc_last[s+k] != ((k % FL) == FL - 1)) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic build_exp();
        int s = cap_start();
        exp_q.delete();
        for (int k = 0; k < SAMP; k++) exp_q.push_back(acc_data[s+k]);
    endtask

    // Driver: one clock of stream traffic, then compare status against the model.
    task automatic cycle(input logic vld, input logic do_arm);
        logic tl;
        logic acc_now;
        int   n;
        tl = ((cnt % FL) == FL - 1);
        if (inj_en && armed && vld && (captured_n() == 5)) tl = ~tl;
        s_axis_tvalid = vld;
        s_axis_tdata  = 32'(cnt);
        s_axis_tlast  = tl;
        arm           = do_arm;
        acc_now       = vld & s_axis_tready;
        @(posedge clk);
        #1;
        if (acc_now) begin
            acc_data.push_back(32'(cnt));
            acc_last.push_back(tl);
            cnt++;
        end
        if (do_arm) begin
            armed = 1'b1;
            acc_data.delete();
            acc_last.delete();
        end
        arm = 1'b0;
        n = captured_n();
        check("tready", s_axis_tready, 1);
        check("full", full, (armed && n == SAMP));
        check("busy", busy, (armed && n < SAMP));
        check("frame_cnt", frame_cnt, n / FL);
        check("tlast_err", tlast_err, exp_err());
    endtask

    task automatic run_to_full(input bit toggle);
        int budget = 300;
        while (budget > 0 && captured_n() < SAMP) begin
            budget--;
            cycle(toggle ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        end
        check("capture_done", captured_n(), SAMP);
    endtask

    task automatic readback(input int base);
        for (int a = 0; a < SAMP; a++) begin
            rd_addr = 4'(a);
            cycle(1'b1, 1'b0);
            check("rd_data", rd_data, exp_q[a]);
            if (base >= 0) check("rd_abs", rd_data, 32'(base + a));
        end
    endtask

    initial begin
        int budget;
        rst = 1'b1; arm = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        s_axis_tlast = 1'b0; rd_addr = '0;

        // Reset state
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_tready", s_axis_tready, 0);
            check("rst_busy", busy, 0);
            check("rst_full", full, 0);
            check("rst_frame_cnt", frame_cnt, 0);
            check("rst_tlast_err", tlast_err, 0);
            check("rst_rd_data", rd_data, 0);
            check("rst_state", dbg_state, IDLE);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("tready_after_rst", s_axis_tready, 1);

        // Continuous stream, arm 3 beats after the tlast at counter 7
        while (cnt < 11) cycle(1'b1, 1'b0);
        check("idle_state", dbg_state, IDLE);
        cycle(1'b1, 1'b1);
        check("armed_state", dbg_state, ALIGN);
        run_to_full(1'b0);
        check("a_frame_cnt", frame_cnt, 2);
        check("a_last_beat", acc_data[cap_start() + SAMP - 1], 39);
        build_exp();
        readback(24);

        // Re-arm from FULL, misplaced tlast at capture offset 5
        cycle(1'b1, 1'b1);
        check("rearm_state", dbg_state, ALIGN);
        check("rearm_full", full, 0);
        inj_en = 1'b1;
        run_to_full(1'b0);
        inj_en = 1'b0;
`ifdef OSPFB_CAPTURE_TLAST_CHECK_EN
        check("b_tlast_err", tlast_err, 1);
`else
        check("b_tlast_err", tlast_err, 0);
`endif
        build_exp();
        readback(-1);

        // Random 50% tvalid
        cycle(1'b1, 1'b1);
        run_to_full(1'b1);
        build_exp();
        readback(-1);

        // Reset after 6 captured beats, then re-arm
        cycle(1'b1, 1'b1);
        budget = 100;
        while (budget > 0 && captured_n() < 6) begin
            budget--;
            cycle(1'b1, 1'b0);
        end
        check("d_six_beats", captured_n(), 6);
        rst = 1'b1;
        armed = 1'b0;
        acc_data.delete();
        acc_last.delete();
        #1;
        check("d_rst_tready", s_axis_tready, 0);
        check("d_rst_busy", busy, 0);
        check("d_rst_frame_cnt", frame_cnt, 0);
        check("d_rst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        check("d_rst_tready2", s_axis_tready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("d_tready", s_axis_tready, 1);
        cycle(1'b1, 1'b1);
        check("d_state", dbg_state, ALIGN);
        check("d_frame_cnt", frame_cnt, 0);
        run_to_full(1'b0);
        build_exp();
        readback(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
